// File: rtl/stack_data_mem.sv
// Byte-addressed data memory with a downward-growing hardware stack.
// LOAD/STORE address the memory directly; PUSH/POP/CALL/RET move sp.
// Any illegal access is suppressed and latched as a sticky fault until fault_clr.
module stack_data_mem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int STACK_BASE  = 2**ADDR_W,
    parameter int STACK_LIMIT = 2**ADDR_W - 256,
    parameter int PC_INC      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [2:0]            op,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [DATA_W-1:0]     pc,
    input  logic                  fault_clr,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ret_valid,
    output logic [DATA_W-1:0]     ret_pc,
    output logic [ADDR_W:0]       sp,
    output logic                  fault,
    output logic [2:0]            fault_code
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 2**ADDR_W;
    localparam int SP_W  = ADDR_W + 1;
    // One extra bit beyond sp so that sp +/- BYTES comparisons never wrap.
    localparam int CW    = ADDR_W + 2;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_ALIGN = 3'd1;
    localparam logic [2:0] FC_RANGE = 3'd2;
    localparam logic [2:0] FC_OVF   = 3'd3;
    localparam logic [2:0] FC_UNF   = 3'd4;
    localparam logic [2:0] FC_ILL   = 3'd5;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4,
        OP_CALL  = 3'd5,
        OP_RET   = 3'd6,
        OP_ILL   = 3'd7
    } op_e;

    logic [7:0]        mem [DEPTH];

    logic [SP_W-1:0]   sp_q, sp_d;
    logic              rvalid_q, rvalid_d;
    logic              ret_valid_q, ret_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] ret_pc_q, ret_pc_d;
    logic              fault_q, fault_d;
    logic [2:0]        fault_code_q, fault_code_d;

    op_e               op_t;
    logic              accept;
    logic              misaligned, out_of_range, overflow, underflow;
    logic [2:0]        op_code;
    logic              op_fault;
    logic [ADDR_W-1:0] raddr, waddr;
    logic [DATA_W-1:0] rd_word, wword;
    logic [BYTES-1:0]  wlanes;
    logic              we;

    assign op_t   = op_e'(op);
    assign ready  = !fault_q;
    assign accept = req && ready;

    assign misaligned   = (CW'(addr) % CW'(BYTES)) != '0;
    assign out_of_range = (CW'(addr) + CW'(BYTES)) > CW'(DEPTH);
    assign overflow     = CW'(sp_q) < (CW'(STACK_LIMIT) + CW'(BYTES));
    assign underflow    = (CW'(sp_q) + CW'(BYTES)) > CW'(STACK_BASE);

    // Classify the requested operation's fault, highest priority first.
    always_comb begin
        op_code = FC_NONE;
        case (op_t)
            OP_ILL: op_code = FC_ILL;
            OP_LOAD, OP_STORE: begin
                if (misaligned)        op_code = FC_ALIGN;
                else if (out_of_range) op_code = FC_RANGE;
            end
            OP_PUSH, OP_CALL: if (overflow)  op_code = FC_OVF;
            OP_POP,  OP_RET:  if (underflow) op_code = FC_UNF;
            default: ;
        endcase
    end

    assign op_fault = op_code != FC_NONE;

    // Little-endian word read from either the LOAD address or the stack top.
    always_comb begin
        raddr   = ((op_t == OP_POP) || (op_t == OP_RET)) ? sp_q[ADDR_W-1:0] : addr;
        rd_word = '0;
        for (int k = 0; k < BYTES; k++) begin
            rd_word[8*k +: 8] = mem[raddr + ADDR_W'(k)];
        end
    end

    // Next-state for sp, result registers, fault flag, and the memory write port.
    always_comb begin
        sp_d         = sp_q;
        rvalid_d     = 1'b0;
        ret_valid_d  = 1'b0;
        rdata_d      = rdata_q;
        ret_pc_d     = ret_pc_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        we           = 1'b0;
        waddr        = addr;
        wword        = wdata;
        wlanes       = byte_en;

        if (fault_clr) begin
            fault_d      = 1'b0;
            fault_code_d = FC_NONE;
        end

        if (accept) begin
            if (op_fault) begin
                fault_d      = 1'b1;
                fault_code_d = op_code;
            end else begin
                case (op_t)
                    OP_LOAD: begin
                        rdata_d  = rd_word;
                        rvalid_d = 1'b1;
                    end
                    OP_STORE: we = 1'b1;
                    OP_PUSH, OP_CALL: begin
                        we     = 1'b1;
                        sp_d   = sp_q - SP_W'(BYTES);
                        waddr  = sp_q[ADDR_W-1:0] - ADDR_W'(BYTES);
                        wlanes = '1;
                        if (op_t == OP_CALL) wword = pc + DATA_W'(PC_INC);
                    end
                    OP_POP: begin
                        rdata_d  = rd_word;
                        rvalid_d = 1'b1;
                        sp_d     = sp_q + SP_W'(BYTES);
                    end
                    OP_RET: begin
                        ret_pc_d    = rd_word;
                        ret_valid_d = 1'b1;
                        sp_d        = sp_q + SP_W'(BYTES);
                    end
                    default: ;
                endcase
            end
        end

        // Reset discards the operation, including its memory write.
        if (rst) we = 1'b0;
    end

    // Memory array: lane-masked writes, contents survive reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < BYTES; k++) begin
            if (we && wlanes[k]) mem[waddr + ADDR_W'(k)] <= wword[8*k +: 8];
        end
    end

    // Control and result registers; reset overrides any operation and fault_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q         <= SP_W'(STACK_BASE);
            rvalid_q     <= 1'b0;
            ret_valid_q  <= 1'b0;
            rdata_q      <= '0;
            ret_pc_q     <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            sp_q         <= sp_d;
            rvalid_q     <= rvalid_d;
            ret_valid_q  <= ret_valid_d;
            rdata_q      <= rdata_d;
            ret_pc_q     <= ret_pc_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign sp         = sp_q;
    assign rvalid     = rvalid_q;
    assign ret_valid  = ret_valid_q;
    assign rdata      = rdata_q;
    assign ret_pc     = ret_pc_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_stack_data_mem.sv
// Bench for stack_data_mem: directed scenarios followed by random traffic,
// all compared against a word/byte-level reference model of the block.
module tb_stack_data_mem;

    localparam int DW = 32;
    localparam int AW = 10;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, STORE = 3'd2, PUSH = 3'd3,
                           POP = 3'd4, CALL = 3'd5, RET = 3'd6, ILL = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic [2:0]    op = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    byte_en = '0;
    logic [DW-1:0] pc = '0;
    logic          fault_clr = 1'b0;
    logic          ready, rvalid, ret_valid, fault;
    logic [DW-1:0] rdata, ret_pc;
    logic [AW:0]   sp;
    logic [2:0]    fault_code;

    stack_data_mem dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .byte_en(byte_en), .pc(pc), .fault_clr(fault_clr), .ready(ready),
        .rvalid(rvalid), .rdata(rdata), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .sp(sp), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_sp;
    bit            m_fault, m_rv, m_retv;
    int            m_code;
    logic [DW-1:0] m_rdata, m_retpc;
    logic [7:0]    mm [1024];

    function automatic logic [DW-1:0] mword(input int a);
        return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
    endfunction

    task automatic mput(input int a, input logic [DW-1:0] d, input logic [3:0] be);
        for (int k = 0; k < 4; k++) if (be[k]) mm[a+k] = d[8*k +: 8];
    endtask

    task automatic model(input bit r, input bit rq, input logic [2:0] o, input int a,
                         input logic [DW-1:0] wd, input logic [3:0] be,
                         input logic [DW-1:0] p, input bit fc);
        bit acc;
        int code;
        m_rv   = 0;
        m_retv = 0;
        if (r) begin
            m_sp = 1024; m_fault = 0; m_code = 0; m_rdata = '0; m_retpc = '0;
            return;
        end
        acc = rq && !m_fault;
        if (fc) begin m_fault = 0; m_code = 0; end
        if (!acc) return;
        code = 0;
        if (o == ILL)                                        code = 5;
        else if ((o == LOAD || o == STORE) && (a % 4 != 0))  code = 1;
        else if ((o == LOAD || o == STORE) && (a + 4 > 1024)) code = 2;
        else if ((o == PUSH || o == CALL) && (m_sp - 4 < 768)) code = 3;
        else if ((o == POP || o == RET) && (m_sp + 4 > 1024)) code = 4;
        if (code != 0) begin
            m_fault = 1; m_code = code;
            return;
        end
        case (o)
            LOAD:  begin m_rdata = mword(a); m_rv = 1; end
            STORE: mput(a, wd, be);
            PUSH:  begin m_sp -= 4; mput(m_sp, wd, 4'hF); end
            CALL:  begin m_sp -= 4; mput(m_sp, p + 32'd4, 4'hF); end
            POP:   begin m_rdata = mword(m_sp); m_rv = 1; m_sp += 4; end
            RET:   begin m_retpc = mword(m_sp); m_retv = 1; m_sp += 4; end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic step(input bit r, input bit rq, input logic [2:0] o, input int a,
                        input logic [DW-1:0] wd, input logic [3:0] be,
                        input logic [DW-1:0] p, input bit fc);
        rst = r; req = rq; op = o; addr = AW'(a); wdata = wd; byte_en = be;
        pc = p; fault_clr = fc;
        model(r, rq, o, a, wd, be, p, fc);
        @(posedge clk);
        #1;
        chk("sp",         32'(sp),         32'(m_sp));
        chk("rvalid",     32'(rvalid),     32'(m_rv));
        chk("ret_valid",  32'(ret_valid),  32'(m_retv));
        chk("rdata",      rdata,           m_rdata);
        chk("ret_pc",     ret_pc,          m_retpc);
        chk("fault",      32'(fault),      32'(m_fault));
        chk("fault_code", 32'(fault_code), 32'(m_code));
        chk("ready",      32'(ready),      32'(!m_fault));
    endtask

    task automatic opx(input logic [2:0] o, input int a, input logic [DW-1:0] wd,
                       input logic [3:0] be, input logic [DW-1:0] p);
        step(0, 1, o, a, wd, be, p, 0);
    endtask

    task automatic idle();
        step(0, 0, NOP, 0, '0, '0, '0, 0);
    endtask

    task automatic clr();
        step(0, 0, NOP, 0, '0, '0, '0, 1);
    endtask

    initial begin
        bit            r, rq, fc;
        logic [2:0]    o;
        logic [AW-1:0] a;

        // Reset state
        step(1, 0, NOP, 0, '0, '0, '0, 0);
        chk("reset_sp", 32'(sp), 32'd1024);

        // Byte-lane store merge then load
        opx(STORE, 16, 32'hA1B2C3D4, 4'hF, '0);
        opx(STORE, 16, 32'h000000FF, 4'h1, '0);
        opx(LOAD, 16, '0, '0, '0);
        chk("merge_rdata", rdata, 32'hA1B2C3FF);
        chk("merge_rvalid", 32'(rvalid), 32'd1);
        idle();

        // Push / pop ordering
        opx(PUSH, 0, 32'h11, '0, '0);
        opx(PUSH, 0, 32'h22, '0, '0);
        chk("push2_sp", 32'(sp), 32'd1016);
        opx(POP, 0, '0, '0, '0);
        chk("pop1_rdata", rdata, 32'h22);
        opx(POP, 0, '0, '0, '0);
        chk("pop2_rdata", rdata, 32'h11);
        chk("pop2_sp", 32'(sp), 32'd1024);

        // Call / return
        opx(CALL, 0, '0, '0, 32'h100);
        chk("call_sp", 32'(sp), 32'd1020);
        opx(RET, 0, '0, '0, '0);
        chk("ret_pc", ret_pc, 32'h104);
        chk("ret_rvalid", 32'(rvalid), 32'd0);
        idle();

        // Underflow at reset, sticky until fault_clr, clr blocks same-cycle request
        step(1, 0, NOP, 0, '0, '0, '0, 0);
        opx(POP, 0, '0, '0, '0);
        chk("unf_code", 32'(fault_code), 32'd4);
        opx(PUSH, 0, 32'h55, '0, '0);
        step(0, 1, PUSH, 0, 32'h66, '0, '0, 1);
        chk("clr_ready", 32'(ready), 32'd1);
        chk("clr_sp", 32'(sp), 32'd1024);

        // Fill the stack, then overflow and address faults
        for (int i = 0; i < 64; i++) opx(PUSH, 0, 32'(1000 + i), '0, '0);
        chk("full_sp", 32'(sp), 32'd768);
        opx(PUSH, 0, 32'hDEAD, '0, '0);
        chk("ovf_code", 32'(fault_code), 32'd3);
        clr();
        opx(LOAD, 6, '0, '0, '0);
        chk("mis6_code", 32'(fault_code), 32'd1);
        clr();
        opx(LOAD, 1021, '0, '0, '0);
        chk("mis1021_code", 32'(fault_code), 32'd1);
        clr();
        opx(LOAD, 1020, '0, '0, '0);
        chk("load1020", rdata, 32'd1000);
        opx(ILL, 0, '0, '0, '0);
        chk("ill_code", 32'(fault_code), 32'd5);
        clr();

        // Request discarded by a simultaneous reset
        step(1, 1, LOAD, 1020, '0, '0, '0, 0);
        chk("rst_load_rdata", rdata, 32'd0);

        // Initialise the low region so random loads read defined data
        for (int i = 0; i < 64; i++) opx(STORE, 4*i, $urandom, 4'hF, '0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            rq = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 12))
                0:          o = NOP;
                1, 2, 3:    o = LOAD;
                4, 5:       o = STORE;
                6, 7:       o = PUSH;
                8, 9:       o = POP;
                10:         o = CALL;
                11:         o = RET;
                default:    o = ILL;
            endcase
            a = AW'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            fc = m_fault && ($urandom_range(0, 3) == 0);
            step(r, rq, o, int'(a), $urandom, 4'($urandom), $urandom, fc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_data_mem.md
STACK_DATA_MEM -- requirements
Module: stack_data_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; multiple of 8; BYTES = DATA_W/8.
REQ-002 SHALL have parameter ADDR_W, default 10, byte-address width; memory depth = 2^ADDR_W bytes.
REQ-003 SHALL have parameter STACK_BASE, default 2^ADDR_W, the reset value of sp and the top of the stack (exclusive).
REQ-004 SHALL have parameter STACK_LIMIT, default 2^ADDR_W-256, the lowest legal sp.
REQ-005 SHALL have parameter PC_INC, default 4, the increment added to pc by CALL.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk input 1 bit, rising-edge clock; rst input 1 bit, synchronous active-high reset.
REQ-007 SHALL have the following ports (name, direction, width, meaning):
- req, input, 1, operation request.
- op, input, 3, operation: 0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 illegal.
- addr, input, ADDR_W, byte address for LOAD/STORE.
- wdata, input, DATA_W, data for STORE/PUSH.
- byte_en, input, BYTES, byte lane enables for STORE.
- pc, input, DATA_W, current program counter for CALL.
- fault_clr, input, 1, clears the sticky fault.
- ready, output, 1, block can accept an operation.
- rvalid, output, 1, rdata valid pulse for LOAD/POP.
- rdata, output, DATA_W, read data.
- ret_valid, output, 1, ret_pc valid pulse for RET.
- ret_pc, output, DATA_W, popped return address.
- sp, output, ADDR_W+1, current stack pointer.
- fault, output, 1, sticky fault flag.
- fault_code, output, 3, cause of the first fault.

Function
REQ-008 SHALL accept an operation only in a cycle where req=1 and ready=1; all inputs are sampled at that clk edge.
REQ-009 SHALL drive ready = !fault.
REQ-010 SHALL store words little-endian: byte k of a word at byte address a+k.
REQ-011 SHALL perform LOAD by returning mem[addr..addr+BYTES-1] on rdata with rvalid=1 in the cycle after acceptance (1-cycle latency).
REQ-012 SHALL perform STORE by writing only the lanes enabled in byte_en at the acceptance edge; a subsequent LOAD returns the new data.
REQ-013 SHALL perform PUSH as sp <= sp-BYTES, with wdata written at the new sp, at the same edge.
REQ-014 SHALL perform POP by returning the word at sp on rdata with rvalid the next cycle, and sp <= sp+BYTES at the acceptance edge.
REQ-015 SHALL perform CALL as PUSH, with data pc+PC_INC (modulo 2^DATA_W).
REQ-016 SHALL perform RET as POP, except the result goes to ret_pc with ret_valid, and rvalid stays 0.
REQ-017 SHALL hold rvalid and ret_valid high for exactly one cycle per completing operation; rdata and ret_pc hold their last value otherwise.
REQ-018 SHALL treat NOP, and any cycle with req=0, as changing no state.
REQ-019 SHALL detect faults, checked in this priority order, for an accepted operation:
- illegal op (code 5).
- LOAD/STORE with addr not a multiple of BYTES (code 1).
- LOAD/STORE with addr+BYTES > 2^ADDR_W (code 2).
- PUSH/CALL with sp-BYTES < STACK_LIMIT (code 3, overflow).
- POP/RET with sp+BYTES > STACK_BASE (code 4, underflow).
REQ-020 SHALL, on a fault, suppress the faulting operation entirely (no memory write, no sp change, no valid pulse), set fault=1, and latch fault_code.
REQ-021 SHALL keep fault and fault_code until a cycle with fault_clr=1, which clears both at that edge; an operation requested in that same cycle is not accepted because ready=0.
REQ-022 SHALL compute sp arithmetic in ADDR_W+1 bits, so that sp=2^ADDR_W is representable and no wrap-around occurs.

Reset
REQ-023 SHALL, on a clk edge with rst=1, set sp=STACK_BASE, rvalid=0, ret_valid=0, rdata=0, ret_pc=0, fault=0 and fault_code=0, so that ready=1.
REQ-024 SHALL give rst priority over every operation and over fault_clr; an operation accepted in the reset cycle is discarded, including its pending valid pulse.
REQ-025 SHALL NOT reset memory contents.

Verification (DATA_W=32, ADDR_W=10, STACK_BASE=1024, STACK_LIMIT=768)
REQ-026 STORE 0xA1B2C3D4 at addr 16 with byte_en=1111, then STORE 0x000000FF at addr 16 with byte_en=0001, then LOAD 16 -> rdata=0xA1B2C3FF, rvalid one cycle after the LOAD.
REQ-027 PUSH 0x11, then PUSH 0x22 -> sp=1016; POP -> rdata=0x22, sp=1020; POP -> rdata=0x11, sp=1024.
REQ-028 CALL with pc=0x100 -> sp=1020; RET -> ret_pc=0x104, ret_valid=1 for one cycle, rvalid=0, sp=1024.
REQ-029 POP at reset -> fault=1, fault_code=4, sp=1024, no rvalid; ready stays 0; fault_clr -> fault=0, ready=1.
REQ-030 64 PUSHes -> sp=768; 65th PUSH -> fault_code=3, sp stays 768. LOAD at addr 6 -> fault_code=1. LOAD at addr 1021 -> fault_code=1. LOAD at addr 1024-4=1020 -> succeeds.
REQ-031 LOAD accepted on the same edge rst=1 is asserted -> no rvalid, sp=1024, rdata=0.
